// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD sequencer: FSM encoding,
// double-dabble correction constants and digit-count sizing helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A BCD digit at or above this value overflows past 9 when doubled,
  // so it is pre-corrected before the shift.
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Smallest number of decimal digits able to hold any bin_w-bit unsigned
  // value, i.e. the least d with 10^d >= 2^bin_w.
  function automatic int min_digits(input int bin_w);
    longint unsigned lim;
    longint unsigned pw;
    int              d;
    lim = 64'd1 << bin_w;
    pw  = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (pw < lim) begin
        pw = pw * 64'd10;
        d  = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_code_seq_if.sv
// Handshake bundle between a producer/consumer and the BCD sequencer.
// The master side drives operands and accepts results; the slave is the
// converter itself.
interface bcd_code_seq_if #(
  parameter int BIN_W = 8,
  parameter int DIG_N = 3
);

  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic [BIN_W-1:0]   num_in;
  logic               out_valid;
  logic               out_ready;
  logic [4*DIG_N-1:0] num_out;
  logic               sign_out;

  modport master (
    output clr,
    output in_valid,
    output num_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  num_out,
    input  sign_out
  );

  modport slave (
    input  clr,
    input  in_valid,
    input  num_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output num_out,
    output sign_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble corrector: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;

endmodule

// File: rtl/bcd_code_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One operand is
// accepted in IDLE, converted one bit per cycle in SHIFT, and presented
// in DONE until the consumer takes it. Optional two's-complement input
// produces a magnitude plus sign flag.
module bcd_code_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 8,
  parameter int DIG_N     = 3,
  parameter int SIGNED_EN = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  bcd_code_seq_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIG_N;
  localparam int SR_W  = BCD_W + BIN_W;

  // Reject configurations that cannot represent every input value.
  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $fatal(1, "bcd_code_seq: BIN_W must lie in 4..32");
  end
  if (DIG_N < min_digits(BIN_W)) begin : g_bad_dig_n
    $fatal(1, "bcd_code_seq: DIG_N too small to hold 2^BIN_W-1");
  end

  state_e           state;
  state_e           state_nxt;
  logic [SR_W-1:0]  sr;        // {BCD accumulator, binary operand}
  logic [CNT_W-1:0] cnt;       // remaining shift steps
  logic             sign_q;
  logic [BCD_W-1:0] bcd_adj;   // accumulator after per-digit correction
  logic [BIN_W-1:0] load_mag;  // unsigned magnitude of the incoming operand
  logic             load_sign;
  logic             accept;

  assign accept = bus.in_valid && (state == ST_IDLE);

  // Per-digit add-3 correction applied ahead of every shift.
  for (genvar g = 0; g < DIG_N; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (sr[BIN_W + 4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  // Operand magnitude and sign; the most negative value negates to itself,
  // which read as unsigned is exactly its magnitude 2^(BIN_W-1).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    load_mag  = bus.num_in;
    load_sign = 1'b0;
    if (SIGNED_EN != 0 && bus.num_in[BIN_W-1]) begin
      load_mag  = -bus.num_in;
      load_sign = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from before the edge.
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; clr overrides every transition, including accept.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)                state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(1))      state_nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready)         state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
    if (bus.clr) begin
      state_nxt = ST_IDLE;
    end
  end

  // Shift register, bit counter and sign: load on accept, correct-and-shift
  // while converting, hold the finished result through any output stall.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
    end else if (bus.clr) begin
      sr     <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            sr     <= {{BCD_W{1'b0}}, load_mag};
            cnt    <= CNT_W'(BIN_W);
            sign_q <= load_sign;
          end
        end
        ST_SHIFT: begin
          sr  <= {bcd_adj, sr[BIN_W-1:0]} << 1;
          cnt <= cnt - CNT_W'(1);
        end
        default: begin
          // DONE: result held until taken or cleared
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.num_out   = sr[SR_W-1 -: BCD_W];
  assign bus.sign_out  = (SIGNED_EN != 0) ? sign_q : 1'b0;

endmodule

// File: tb/tb_bcd_code_seq.sv
// Bench for bcd_code_seq: an unsigned and a signed 8-bit instance run in
// lockstep on shared stimulus, plus a 16-bit instance. Expected results are
// queued at accept time from an arithmetic reference and popped on out_valid.
module tb_bcd_code_seq;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge sys_clk) cyc++;

  // Shared stimulus for both 8-bit instances.
  logic       clr, in_valid, out_ready;
  logic [7:0] num_in;
  // Stimulus for the 16-bit instance.
  logic        w_clr, w_valid, w_out_ready;
  logic [15:0] w_num;

  bcd_code_seq_if #(.BIN_W(8),  .DIG_N(3)) bus_u ();
  bcd_code_seq_if #(.BIN_W(8),  .DIG_N(3)) bus_s ();
  bcd_code_seq_if #(.BIN_W(16), .DIG_N(5)) bus_w ();

  assign bus_u.clr = clr;   assign bus_u.in_valid = in_valid;
  assign bus_u.num_in = num_in; assign bus_u.out_ready = out_ready;
  assign bus_s.clr = clr;   assign bus_s.in_valid = in_valid;
  assign bus_s.num_in = num_in; assign bus_s.out_ready = out_ready;
  assign bus_w.clr = w_clr; assign bus_w.in_valid = w_valid;
  assign bus_w.num_in = w_num;  assign bus_w.out_ready = w_out_ready;

  bcd_code_seq #(.BIN_W(8), .DIG_N(3), .SIGNED_EN(0)) u_dut_u (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (bus_u));
  bcd_code_seq #(.BIN_W(8), .DIG_N(3), .SIGNED_EN(1)) u_dut_s (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (bus_s));
  bcd_code_seq #(.BIN_W(16), .DIG_N(5), .SIGNED_EN(0)) u_dut_w (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .bus (bus_w));

  typedef struct {
    logic [11:0] u_bcd;
    logic [11:0] s_bcd;
    logic        s_sign;
  } exp8_t;

  exp8_t       q8[$];
  logic [19:0] q16[$];

  // Decimal digits by repeated division, independent of shift-and-add-3.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Present v to both 8-bit instances and queue the expected results.
  task automatic accept8(input logic [7:0] v, output int acc_cyc);
    int    n;
    exp8_t e;
    n        = 0;
    num_in   = v;
    in_valid = 1'b1;
    while (!bus_u.in_ready && n < 40) begin
      step();
      n++;
    end
    check("in_ready_before_accept", bus_u.in_ready, 1);
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    e.u_bcd  = 12'(ref_bcd(int'(v)));
    e.s_bcd  = v[7] ? 12'(ref_bcd(256 - int'(v))) : 12'(ref_bcd(int'(v)));
    e.s_sign = v[7];
    q8.push_back(e);
  endtask

  // Wait for the result, compare against the queue, optionally stall it.
  task automatic finish8(input int stall, input string tag);
    int          lat;
    logic        rdy_seen;
    logic        stable;
    exp8_t       e;
    logic [11:0] held;
    lat       = 0;
    rdy_seen  = 1'b0;
    stable    = 1'b1;
    out_ready = (stall == 0);
    while (!bus_u.out_valid && lat < 40) begin
      if (bus_u.in_ready || bus_s.in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, "/latency"}, lat, 8);
    check({tag, "/in_ready_busy"}, rdy_seen, 0);
    check({tag, "/s_out_valid"}, bus_s.out_valid, 1);
    check({tag, "/sb_depth"}, q8.size(), 1);
    if (q8.size() != 0) begin
      e = q8.pop_front();
      check({tag, "/u_num_out"}, bus_u.num_out, e.u_bcd);
      check({tag, "/u_sign_out"}, bus_u.sign_out, 0);
      check({tag, "/s_num_out"}, bus_s.num_out, e.s_bcd);
      check({tag, "/s_sign_out"}, bus_s.sign_out, e.s_sign);
    end
    held = bus_u.num_out;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!bus_u.out_valid || bus_u.num_out !== held) stable = 1'b0;
    end
    if (stall > 0) check({tag, "/stall_stable"}, stable, 1);
    out_ready = 1'b1;
    step();
    check({tag, "/released"}, bus_u.out_valid, 0);
    check({tag, "/idle_again"}, bus_u.in_ready, 1);
  endtask

  task automatic conv16(input logic [15:0] v, input string tag);
    int          lat;
    logic [19:0] e;
    lat         = 0;
    w_out_ready = 1'b1;
    w_num       = v;
    w_valid     = 1'b1;
    check({tag, "/in_ready"}, bus_w.in_ready, 1);
    step();
    w_valid = 1'b0;
    q16.push_back(ref_bcd(int'(v)));
    while (!bus_w.out_valid && lat < 60) begin
      step();
      lat++;
    end
    check({tag, "/latency"}, lat, 16);
    check({tag, "/sb_depth"}, q16.size(), 1);
    if (q16.size() != 0) begin
      e = q16.pop_front();
      check({tag, "/num_out"}, bus_w.num_out, e);
    end
    step();
    check({tag, "/released"}, bus_w.out_valid, 0);
  endtask

  // Start a 200 conversion and kill it in SHIFT by clr or by reset.
  task automatic abort8(input logic use_rst, input string tag);
    int    a, ov;
    exp8_t d;
    ov = 0;
    out_ready = 1'b1;
    accept8(8'd200, a);
    d = q8.pop_back();
    repeat (4) step();
    check({tag, "/in_shift"}, bus_u.in_ready, 0);
    if (use_rst) begin
      sys_rst_n = 1'b0;
      #1;
      check({tag, "/async_ready"}, bus_u.in_ready, 1);
      check({tag, "/async_num_out"}, bus_u.num_out, 0);
      #2;
      sys_rst_n = 1'b1;
      step();
    end else begin
      clr = 1'b1;
      step();
      clr = 1'b0;
    end
    check({tag, "/idle"}, bus_u.in_ready, 1);
    check({tag, "/no_valid"}, bus_u.out_valid, 0);
    repeat (12) begin
      if (bus_u.out_valid || bus_s.out_valid) ov++;
      step();
    end
    check({tag, "/no_late_valid"}, ov, 0);
    accept8(8'd42, a);
    finish8(0, {tag, "/after_42"});
  endtask

  initial begin
    int    a0, a1, a2, n;
    exp8_t d;
    sys_rst_n   = 1'b0;
    clr         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    num_in      = '0;
    w_clr       = 1'b0;
    w_valid     = 1'b0;
    w_out_ready = 1'b1;
    w_num       = '0;

    // Reset state
    #2;
    check("rst/in_ready", bus_u.in_ready, 1);
    check("rst/out_valid", bus_u.out_valid, 0);
    check("rst/num_out", bus_u.num_out, 0);
    check("rst/s_sign_out", bus_s.sign_out, 0);
    check("rst/w_num_out", bus_w.num_out, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    step();
    check("rst/first_edge_idle", bus_u.in_ready, 1);

    // Full scale, then back-to-back accept spacing
    accept8(8'd255, a0);
    finish8(0, "u255");
    accept8(8'd0, a0);
    finish8(0, "b2b_0");
    accept8(8'd9, a1);
    finish8(0, "b2b_9");
    accept8(8'd10, a2);
    finish8(0, "b2b_10");
    check("b2b/spacing1", a1 - a0, 10);
    check("b2b/spacing2", a2 - a1, 10);

    // Long output stall
    accept8(8'd137, a0);
    finish8(20, "stall_137");

    // Signed boundaries
    accept8(8'h80, a0);
    finish8(0, "s_80");
    accept8(8'hFF, a0);
    finish8(0, "s_FF");
    accept8(8'h7F, a0);
    finish8(3, "s_7F");

    // clr together with in_valid in IDLE: nothing accepted
    num_in   = 8'd7;
    in_valid = 1'b1;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_vs_valid/not_accepted", bus_u.in_ready, 1);

    // clr in DONE discards the held result
    out_ready = 1'b0;
    accept8(8'd99, a0);
    d = q8.pop_back();
    n = 0;
    while (!bus_u.out_valid && n < 40) begin
      step();
      n++;
    end
    check("clr_done/valid_before", bus_u.out_valid, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_done/dropped", bus_u.out_valid, 0);
    check("clr_done/idle", bus_u.in_ready, 1);
    out_ready = 1'b1;

    // Abort mid-conversion by clr, then by reset
    abort8(1'b0, "abort_clr");
    abort8(1'b1, "abort_rst");

    // Every 8-bit input, both interpretations
    for (int v = 0; v < 256; v++) begin
      accept8(8'(v), a0);
      finish8(0, $sformatf("sweep8_%0d", v));
    end

    // 16-bit instance: boundaries and random samples
    conv16(16'd65535, "w65535");
    conv16(16'd0,     "w0");
    conv16(16'd9999,  "w9999");
    conv16(16'd10000, "w10000");
    conv16(16'd32768, "w32768");
    for (int i = 0; i < 100; i++) begin
      conv16(16'($urandom_range(0, 65535)), $sformatf("wrand_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
